// File: rtl/iir_resp_monitor.sv
// Block-peak monitor for the iir_sos output stream: emits max |d_in| per 2^Nblog2 valid samples.
// Optional block mean output enabled by defining IIR_RESP_MONITOR_MEAN_EN.
//
// state | meaning
// EMPTY | no record held, pk_valid=0
// FULL  | record held on pk_data/pk_index, pk_valid=1
module iir_resp_monitor #(
    parameter int Ndint  = 3,
    parameter int Ndfrac = 22,
    parameter int Nblog2 = 6,
    parameter int Nidx   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          dv_in,
    input  logic signed [Ndint-1:-Ndfrac] d_in,
    output logic                          pk_valid,
    input  logic                          pk_ready,
    output logic [Ndint+Ndfrac-1:0]       pk_data,
    output logic [Nidx-1:0]               pk_index,
    output logic                          pk_overrun
`ifdef IIR_RESP_MONITOR_MEAN_EN
    ,
    output logic signed [Ndint-1:-Ndfrac] pk_mean
`endif
);

    localparam int N = Ndint + Ndfrac;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [N-1:0]      d_raw, mag, peak_acc, result;
    logic [Nblog2-1:0] cnt;
    logic [Nidx-1:0]   blk;
    logic              blk_end, load, set_ovr;

    assign d_raw = d_in;

    // Two's-complement negate; the most negative code lands on 2^(N-1) unsigned.
    always_comb begin
        mag = d_raw[N-1] ? (~d_raw + N'(1)) : d_raw;
    end

    assign blk_end = dv_in && (cnt == {Nblog2{1'b1}});
    assign result  = (mag > peak_acc) ? mag : peak_acc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            peak_acc <= '0;
            cnt      <= '0;
            blk      <= '0;
        end else if (dv_in) begin
            cnt      <= cnt + Nblog2'(1);
            peak_acc <= blk_end ? '0 : result;
            if (blk_end) begin
                blk <= blk + Nidx'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        set_ovr   = 1'b0;
        case (state)
            EMPTY: begin
                if (blk_end) begin
                    load      = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (blk_end) begin
                    if (pk_ready) begin
                        load = 1'b1;
                    end else begin
                        set_ovr = 1'b1;
                    end
                end else if (pk_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    assign pk_valid = (state == FULL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pk_data    <= '0;
            pk_index   <= '0;
            pk_overrun <= 1'b0;
        end else begin
            if (load) begin
                pk_data  <= result;
                pk_index <= blk;
            end
            if (set_ovr) begin
                pk_overrun <= 1'b1;
            end
        end
    end

`ifdef IIR_RESP_MONITOR_MEAN_EN
    localparam int S = N + Nblog2;

    logic [S-1:0] sum_acc, sum_nxt;

    assign sum_nxt = sum_acc + {{Nblog2{d_raw[N-1]}}, d_raw};

    // Taking the upper N bits of the sum is the arithmetic shift by Nblog2 (floor).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_acc <= '0;
            pk_mean <= '0;
        end else begin
            if (dv_in) begin
                sum_acc <= blk_end ? '0 : sum_nxt;
            end
            if (load) begin
                pk_mean <= sum_nxt[S-1:Nblog2];
            end
        end
    end
`endif

endmodule

// File: tb/tb_iir_resp_monitor.sv
// Self-checking bench for iir_resp_monitor: table vectors, random blocks vs a block-level model,
// and hand sequences for reset, overrun and accept-at-block-end. Honours IIR_RESP_MONITOR_MEAN_EN.
module tb_iir_resp_monitor;

    localparam int N   = 25;
    localparam int BLK = 64;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                dv_in = 1'b0;
    logic signed [2:-22] d_in = '0;
    logic                pk_valid;
    logic                pk_ready = 1'b0;
    logic [N-1:0]        pk_data;
    logic [15:0]         pk_index;
    logic                pk_overrun;
`ifdef IIR_RESP_MONITOR_MEAN_EN
    logic signed [2:-22] pk_mean;
`endif

    iir_resp_monitor dut (
        .clk        (clk),
        .resetn     (resetn),
        .dv_in      (dv_in),
        .d_in       (d_in),
        .pk_valid   (pk_valid),
        .pk_ready   (pk_ready),
        .pk_data    (pk_data),
        .pk_index   (pk_index),
        .pk_overrun (pk_overrun)
`ifdef IIR_RESP_MONITOR_MEAN_EN
        ,
        .pk_mean    (pk_mean)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_blk = 0;

    logic signed [N-1:0] s [BLK];

    typedef struct {
        logic [N-1:0] fill;
        int           pos;
        logic [N-1:0] spec;
        logic [N-1:0] peak;
        logic [N-1:0] mean;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: peak is the largest |sample| of the block, mean is floor(sum/64).
    function automatic logic [N-1:0] m_peak();
        int best = 0;
        for (int i = 0; i < BLK; i++) begin
            int v = int'(s[i]);
            int a = (v < 0) ? -v : v;
            if (a > best) best = a;
        end
        return N'(best);
    endfunction

    function automatic logic [N-1:0] m_mean();
        longint sum = 0;
        longint q;
        for (int i = 0; i < BLK; i++) sum += longint'(s[i]);
        q = sum / BLK;
        if ((sum % BLK != 0) && (sum < 0)) q -= 1;
        return N'(q);
    endfunction

    task automatic chk_rec(input string name, input logic [N-1:0] peak, input int idx,
                           input logic [N-1:0] mean);
        chk({name, "_valid"}, 64'(pk_valid), 64'd1);
        chk({name, "_data"}, 64'(pk_data), 64'(peak));
        chk({name, "_index"}, 64'(pk_index), 64'(16'(idx)));
`ifdef IIR_RESP_MONITOR_MEAN_EN
        chk({name, "_mean"}, 64'(pk_mean), 64'(mean));
`else
        if (mean === 'x) $display("note: mean unknown");
`endif
    endtask

    task automatic put(input logic [N-1:0] v);
        dv_in = 1'b1;
        d_in  = v;
        @(negedge clk);
        dv_in = 1'b0;
        d_in  = N'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Feeds s[] as one block; returns at the negedge just after the closing strobe's edge.
    task automatic run_block(input int gap, input bit ready_last);
        for (int i = 0; i < BLK; i++) begin
            if (i == BLK - 1) begin
                if (pk_ready) chk("pre_valid", 64'(pk_valid), 64'd0);
                if (ready_last) pk_ready = 1'b1;
            end
            put(s[i]);
            if (i < BLK - 1) idle(gap - 1);
        end
        exp_blk++;
    endtask

    task automatic fill_random();
        for (int i = 0; i < BLK; i++) begin
            int r = $urandom_range(0, 9);
            if (r == 0)      s[i] = 25'sh1000000;
            else if (r == 1) s[i] = 25'sh0FFFFFF;
            else             s[i] = N'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        dv_in  = 1'b0;
        exp_blk = 0;
        idle(2);
        chk("rst_valid", 64'(pk_valid), 64'd0);
        chk("rst_data", 64'(pk_data), 64'd0);
        chk("rst_index", 64'(pk_index), 64'd0);
        chk("rst_overrun", 64'(pk_overrun), 64'd0);
`ifdef IIR_RESP_MONITOR_MEAN_EN
        chk("rst_mean", 64'(pk_mean), 64'd0);
`endif
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] p0, m0;

        tbl[0] = '{fill: 25'h0400000, pos: 0,  spec: 25'h0400000, peak: 25'h0400000, mean: 25'h0400000};
        tbl[1] = '{fill: 25'h0000000, pos: 10, spec: 25'h1000000, peak: 25'h1000000, mean: 25'h1FC0000};
        tbl[2] = '{fill: 25'h0000000, pos: 63, spec: 25'h0FFFFFF, peak: 25'h0FFFFFF, mean: 25'h003FFFF};
        tbl[3] = '{fill: 25'h1FFFFFF, pos: 0,  spec: 25'h1FFFFFF, peak: 25'h0000001, mean: 25'h1FFFFFF};
        tbl[4] = '{fill: 25'h0000010, pos: 0,  spec: 25'h1FFFF00, peak: 25'h0000100, mean: 25'h000000B};

        // Mid-stream reset: partial block of 20 strobes is discarded.
        idle(3);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            put(N'($urandom));
            idle(6);
        end
        do_reset();

        // Table vectors, strobe every 7th cycle, consumer always ready.
        pk_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < BLK; i++) s[i] = tbl[t].fill;
            s[tbl[t].pos] = tbl[t].spec;
            run_block(7, 1'b0);
            chk_rec($sformatf("tbl%0d", t), tbl[t].peak, t, tbl[t].mean);
            idle(6);
        end

        // Random blocks with random strobe spacing (1 = back-to-back).
        for (int b = 0; b < 6; b++) begin
            fill_random();
            run_block($urandom_range(1, 7), 1'b0);
            chk_rec($sformatf("rnd%0d", b), m_peak(), exp_blk - 1, m_mean());
            chk("rnd_overrun", 64'(pk_overrun), 64'd0);
        end

        // Overrun: three blocks with the consumer stalled.
        do_reset();
        pk_ready = 1'b0;
        fill_random();
        run_block(7, 1'b0);
        p0 = m_peak();
        m0 = m_mean();
        chk_rec("ovr_first", p0, 0, m0);
        chk("ovr_first_flag", 64'(pk_overrun), 64'd0);
        for (int b = 0; b < 2; b++) begin
            fill_random();
            run_block(7, 1'b0);
            chk_rec($sformatf("ovr_hold%0d", b), p0, 0, m0);
            chk("ovr_flag", 64'(pk_overrun), 64'd1);
        end
        pk_ready = 1'b1;
        @(negedge clk);
        chk("ovr_drain_valid", 64'(pk_valid), 64'd0);
        fill_random();
        run_block(7, 1'b0);
        chk_rec("ovr_next", m_peak(), 3, m_mean());
        chk("ovr_sticky", 64'(pk_overrun), 64'd1);

        // Accept edge coincides with block end, back-to-back strobes.
        do_reset();
        pk_ready = 1'b0;
        fill_random();
        run_block(1, 1'b0);
        chk_rec("sim_a", m_peak(), 0, m_mean());
        fill_random();
        run_block(1, 1'b1);
        chk_rec("sim_b", m_peak(), 1, m_mean());
        chk("sim_overrun", 64'(pk_overrun), 64'd0);
        @(negedge clk);
        chk("sim_drain_valid", 64'(pk_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
